tdm_demux: RTL

Receive-side counterpart of the team's TDM multiplexer. It takes the serialized slot stream, one WIDTH-bit sample per clock with CHANNELS slots per frame, and aligns to a frame-sync strobe. It de-interleaves each slot into a shadow register and publishes complete frames as a parallel bus with a one-cycle valid pulse. It sits at the far end of the TDM link, feeding per-channel consumers.

---
 rtl/tdm_pkg.sv | 17 +
 rtl/tdm_demux_if.sv | 26 ++
 rtl/tdm_slot_counter.sv | 41 ++++
 rtl/tdm_demux.sv | 136 +++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared TDM types and defaults for the mux and demux sides
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_e;

    localparam int DEF_WIDTH    = 2;
    localparam int DEF_CHANNELS = 4;
    localparam int SLOT_W       = $clog2(DEF_CHANNELS);

    function automatic int slot_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// rtl/tdm_demux_if.sv - link-side inputs and frame-side outputs of the TDM demultiplexer
interface tdm_demux_if
    import tdm_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS
) ();

    logic [WIDTH-1:0]          din;
    logic                      sync;
    logic [CHANNELS*WIDTH-1:0] out_bus;
    logic                      frame_valid;
    logic                      locked;
    logic                      sync_err;

    modport master (
        output din, sync,
        input  out_bus, frame_valid, locked, sync_err
    );

    modport slave (
        input  din, sync,
        output out_bus, frame_valid, locked, sync_err
    );

endinterface

// File: rtl/tdm_slot_counter.sv
// rtl/tdm_slot_counter.sv - modulo-CHANNELS slot counter with clear and load-to-1
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SLOT_W   = slot_bits(CHANNELS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load1,
    input  logic              en,
    output logic [SLOT_W-1:0] slot
);

    logic [SLOT_W-1:0] slot_q;
    logic [SLOT_W-1:0] slot_d;

    // CHANNELS is a power of two, so the natural overflow is the modulo wrap
    always_comb begin
        slot_d = slot_q;
        if (clr) begin
            slot_d = '0;
        end else if (load1) begin
            slot_d = SLOT_W'(1);
        end else if (en) begin
            slot_d = slot_q + SLOT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot = slot_q;

endmodule

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - frame-synced TDM demultiplexer publishing whole frames on a parallel bus
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int MISS_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    tdm_demux_if.slave  bus
);

    localparam int SLOT_W = slot_bits(CHANNELS);
    localparam int MISS_W = $clog2(MISS_MAX + 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CHANNELS - 1);

    tdm_state_e                          state_q, state_d;
    logic [MISS_W-1:0]                   miss_q, miss_d;
    logic [CHANNELS-2:0][WIDTH-1:0]      shadow_q, shadow_d;
    logic [CHANNELS*WIDTH-1:0]           out_bus_q, out_bus_d;
    logic                                frame_valid_q, frame_valid_d;
    logic                                sync_err_q, sync_err_d;
    logic                                locked_q, locked_d;
    logic [SLOT_W-1:0]                   slot;
    logic                                cnt_clr, cnt_load, cnt_en;
    logic                                misaligned;

    assign misaligned = bus.sync && (slot != '0);

    tdm_slot_counter #(
        .CHANNELS (CHANNELS),
        .SLOT_W   (SLOT_W)
    ) u_slot_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .load1 (cnt_load),
        .en    (cnt_en),
        .slot  (slot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HUNT;
            miss_q        <= '0;
            shadow_q      <= '0;
            out_bus_q     <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            miss_q        <= miss_d;
            shadow_q      <= shadow_d;
            out_bus_q     <= out_bus_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            locked_q      <= locked_d;
        end
    end

    // Missing syncs are only counted at slot 0; a sync anywhere re-arms the flywheel
    always_comb begin
        state_d = state_q;
        miss_d  = miss_q;
        unique case (state_q)
            HUNT: begin
                if (bus.sync) begin
                    state_d = LOCKED;
                    miss_d  = '0;
                end
            end
            LOCKED: begin
                if (bus.sync) begin
                    miss_d = '0;
                end else if (slot == '0) begin
                    miss_d = miss_q + MISS_W'(1);
                    if (miss_d == MISS_W'(MISS_MAX)) begin
                        state_d = HUNT;
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_comb begin
        shadow_d      = shadow_q;
        out_bus_d     = out_bus_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        cnt_clr       = 1'b0;
        cnt_load      = 1'b0;
        cnt_en        = 1'b0;
        locked_d      = (state_d == LOCKED);
        unique case (state_q)
            HUNT: begin
                if (bus.sync) begin
                    shadow_d[0] = bus.din;
                    cnt_load    = 1'b1;
                end
            end
            LOCKED: begin
                // A misaligned sync wins over a last slot, so that frame is never published
                if (misaligned) begin
                    sync_err_d  = 1'b1;
                    shadow_d[0] = bus.din;
                    cnt_load    = 1'b1;
                end else begin
                    for (int i = 0; i < CHANNELS - 1; i++) begin
                        if (slot == SLOT_W'(i)) begin
                            shadow_d[i] = bus.din;
                        end
                    end
                    if (slot == LAST_SLOT) begin
                        out_bus_d     = {bus.din, shadow_q};
                        frame_valid_d = 1'b1;
                    end
                    if (state_d == HUNT) begin
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            default: cnt_clr = 1'b1;
        endcase
    end

    assign bus.out_bus     = out_bus_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.sync_err    = sync_err_q;
    assign bus.locked      = locked_q;

endmodule
